// File: rtl/jerky_checker.sv
// jerky_checker: acquires phase on the jerky count stream and tracks it with a flywheel
module jerky_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [7:0]       count_i,
  input  logic             in_valid_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             frame_o,
  output logic [3:0]       step_o,
  output logic [7:0]       expected_o,
  output logic [ERR_W-1:0] err_count_o
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;
  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d, match_q, match_d, miss_q, miss_d;
  logic [7:0]       expected_q, expected_d;
  logic             err_q, err_d, frame_q, frame_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             anchor, hit;
  logic [3:0]       step_inc, anchor_step;
  function automatic logic [7:0] pat(input logic [3:0] k);
    return k[0] ? 8'h01 << ((k + 4'd1) >> 1) : 8'h01;
  endfunction
  function automatic logic [3:0] anc_step(input logic [7:0] v);
    anc_step = 4'd0;
    for (int i = 1; i < 8; i++)
      if (v[i]) anc_step = (i == 7) ? 4'd0 : 4'(2 * i);
  endfunction
  assign anchor      = $onehot(count_i) && !count_i[0];
  assign anchor_step = anc_step(count_i);
  assign hit         = count_i == pat(step_q);
  assign step_inc    = (step_q == 4'd13) ? 4'd0 : step_q + 4'd1;
  // Acquisition, sync qualification and flywheel tracking on each valid sample
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    frame_d     = 1'b0;
    err_count_d = err_count_q;
    if (in_valid_i) begin
      case (state_q)
        HUNT: if (anchor) begin
          state_d = SYNC;
          step_d  = anchor_step;
          match_d = 4'd1;
        end
        SYNC: if (hit) begin
          step_d  = step_inc;
          state_d = (match_q >= 4'(LOCK_COUNT)) ? LOCKED : SYNC;
          match_d = (match_q >= 4'(LOCK_COUNT)) ? 4'd0 : match_q + 4'd1;
          miss_d  = 4'd0;
        end else begin
          state_d = anchor ? SYNC : HUNT;
          step_d  = anchor ? anchor_step : 4'd0;
          match_d = anchor ? 4'd1 : 4'd0;
        end
        LOCKED: begin
          step_d      = step_inc;
          frame_d     = hit && step_q == 4'd13;
          err_d       = !hit;
          err_count_d = (hit || &err_count_q) ? err_count_q : err_count_q + 1'b1;
          miss_d      = hit ? 4'd0 : miss_q + 4'd1;
          if (!hit && miss_q + 4'd1 >= 4'(MISS_LIMIT)) begin
            state_d = HUNT;
            step_d  = 4'd0;
            miss_d  = 4'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    expected_d = (state_d == HUNT) ? 8'h00 : pat(step_d);
  end
  // State and registered outputs, reset wins over a valid sample
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= HUNT;
      step_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      expected_q  <= '0;
      err_q       <= 1'b0;
      frame_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      err_count_q <= err_count_d;
    end
  end
  assign locked_o    = state_q == LOCKED;
  assign err_o       = err_q;
  assign frame_o     = frame_q;
  assign step_o      = step_q;
  assign expected_o  = expected_q;
  assign err_count_o = err_count_q;
endmodule

// File: tb/tb_jerky_checker.sv
// tb_jerky_checker: directed and random streams checked against a behavioural model
module tb_jerky_checker;
  localparam int LC = 4, ML = 3, EW = 5, CMAX = (1 << EW) - 1;
  logic          clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [7:0]    cnt = 8'h00;
  logic          locked, err, frame;
  logic [3:0]    step;
  logic [7:0]    expected;
  logic [EW-1:0] err_count;
  int checks = 0, errors = 0;
  int ms = 0, mk = 0, mm = 0, mmiss = 0, mcnt = 0, me = 0, mf = 0, gp = 0;
  jerky_checker #(.LOCK_COUNT(LC), .MISS_LIMIT(ML), .ERR_W(EW)) dut (
    .clock_i(clk), .reset_i(rst), .count_i(cnt), .in_valid_i(valid),
    .locked_o(locked), .err_o(err), .frame_o(frame), .step_o(step),
    .expected_o(expected), .err_count_o(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int pat(input int k);
    return (k % 2 == 0) ? 1 : (1 << ((k + 1) / 2));
  endfunction
  function automatic void model(input int r, input int v, input int c);
    int an;
    bit anchor;
    me = 0;
    mf = 0;
    anchor = $countones(c) == 1 && c >= 2;
    an = (2 * $clog2(c)) % 14;
    if (r) begin
      ms = 0; mk = 0; mm = 0; mmiss = 0; mcnt = 0;
    end else if (v) begin
      if (ms == 0) begin
        if (anchor) begin ms = 1; mk = an; mm = 1; end
      end else if (ms == 1) begin
        if (c == pat(mk)) begin
          mk = (mk + 1) % 14;
          if (mm >= LC) begin ms = 2; mmiss = 0; end
          else mm++;
        end else if (anchor) begin
          mk = an; mm = 1;
        end else begin
          ms = 0; mk = 0;
        end
      end else begin
        if (c == pat(mk)) begin
          mf = (mk == 13);
          mmiss = 0;
        end else begin
          me = 1;
          mmiss++;
          if (mcnt < CMAX) mcnt++;
        end
        mk = (mk + 1) % 14;
        if (mmiss >= ML) begin ms = 0; mk = 0; mmiss = 0; end
      end
    end
  endfunction
  task automatic drive(input bit r, input bit v, input int c);
    rst = r;
    valid = v;
    cnt = 8'(c);
    @(posedge clk);
    model(r, v, c);
    #1;
    chk("locked", locked, ms == 2);
    chk("err", err, me);
    chk("frame", frame, mf);
    chk("step", step, ms == 0 ? 0 : mk);
    chk("expected", expected, ms == 0 ? 0 : pat(mk));
    chk("err_count", err_count, mcnt);
  endtask
  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, pat(gp));
      gp = (gp + 1) % 14;
    end
  endtask
  task automatic bad(input int c);
    drive(0, 1, c);
    gp = (gp + 1) % 14;
  endtask
  initial begin
    drive(1, 1, 2);
    chk("rst_step", step, 0);
    gp = 1;
    good(4);
    chk("sync_not_locked", locked, 0);
    good(1);
    chk("lock_after_8", locked, 1);
    good(8);
    chk("frame_128", frame, 1);
    chk("clean_cnt", err_count, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, $urandom_range(255));
    chk("gap_step", step, 0);
    chk("gap_exp", expected, 1);
    good(7);
    bad(0);
    chk("glitch_err", err, 1);
    chk("glitch_cnt", err_count, 1);
    good(1);
    chk("glitch_keep_lock", locked, 1);
    for (int i = 0; i < 3; i++) bad(3);
    chk("loss_lock", locked, 0);
    chk("loss_cnt", err_count, 4);
    chk("loss_exp", expected, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1);
    chk("ones_hunt", expected, 0);
    drive(0, 1, 4);
    chk("anchor4_step", step, 4);
    chk("anchor4_exp", expected, 1);
    gp = 4;
    good(4);
    bad(0);
    chk("cnt5", err_count, 5);
    good(2);
    drive(1, 1, pat(gp));
    chk("rst_cnt", err_count, 0);
    chk("rst_locked", locked, 0);
    gp = 1;
    good(5);
    chk("relock", locked, 1);
    for (int i = 0; i < 35; i++) begin
      bad(0);
      good(1);
    end
    chk("sat_cnt", err_count, CMAX);
    bad(0);
    chk("sat_err_pulse", err, 1);
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(999);
      if (r < 4) drive(1, $urandom_range(1), $urandom_range(255));
      else if (r < 200) drive(0, 0, $urandom_range(255));
      else if (r < 280) bad($urandom_range(255));
      else if (r < 300) bad(3);
      else if (r < 315) gp = $urandom_range(13);
      else good(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jerky_checker.md
# jerky_checker

Receive-side checker for the 8-bit jerky count stream (1, 2, 1, 4, 1, 8, 1, 16, 1, 32, 1, 64, 1, 128, repeating every 14 steps). It sits downstream of the jerky counter or any link carrying its output. It samples the stream on qualified cycles, acquires phase, and tracks the stream with a flywheel. It reports lock, per-sample mismatches, frame completion and a saturating error count to the HW#1 bench and status logic.

## Interface
- LOCK_COUNT, 4, consecutive matching samples in SYNC required to enter LOCKED (legal 1..15)
- MISS_LIMIT, 3, consecutive mismatches in LOCKED that drop lock (legal 1..15)
- ERR_W, 16, width of err_count
- clock  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high
- count  input  8  observed jerky count value
- in_valid  input  1  count is sampled only on cycles where this is 1
- locked  output  1  1 while in LOCKED
- err  output  1  one-cycle pulse on a mismatching sample while LOCKED
- frame  output  1  one-cycle pulse when a matching 128 (step 13) is sampled while LOCKED
- step  output  4  index (0..13) of the next expected sample; 0 outside SYNC/LOCKED
- expected  output  8  value of the next expected sample; 8'h00 outside SYNC/LOCKED
- err_count  output  ERR_W  saturating count of err pulses

## Operation
- Pattern: step k even -> 8'h01; step k odd -> 1 << ((k+1)/2). Step 13 is followed by step 0.
- Anchor: a sample is an anchor if it is one-hot with value >= 2. Value 2^j maps to step 2j-1. The next expected step is 2j mod 14.
- States: HUNT, SYNC, LOCKED. Reset enters HUNT.
- HUNT:
  - Anchor -> SYNC, step = anchor step + 1 mod 14, match counter = 1.
  - 8'h01 is ambiguous; stay in HUNT.
  - Any other value: stay in HUNT. err does not pulse and err_count does not change.
- SYNC:
  - Match -> match counter + 1, step advances.
  - When the counter reaches LOCK_COUNT -> LOCKED, miss counter = 0.
  - Mismatch that is an anchor -> re-anchor from that sample, counter = 1, stay in SYNC.
  - Any other mismatch -> HUNT.
  - No err pulses are generated in SYNC.
- LOCKED:
  - Every valid sample advances step, match or not (flywheel).
  - Match -> miss counter = 0. frame pulses if the matched step is 13.
  - Mismatch -> err pulses, err_count increments (holds at all-ones), miss counter + 1.
  - When the miss counter reaches MISS_LIMIT -> HUNT. On that same sample err still pulses and err_count still increments.
- in_valid = 0: no state, step, counter or err_count change. err and frame are 0.
- LOCK_COUNT = 1: an anchor in HUNT goes directly to SYNC. The next matching sample enters LOCKED.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs immediately after edge N (latency 1 from the input being presented).
- err and frame are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- step and expected always describe the sample to be taken at the next valid edge.
- Reset:
  - Takes priority over in_valid on the same edge.
  - Values after the edge: state HUNT, locked 0, err 0, frame 0, step 0, expected 8'h00, err_count 0, internal counters 0.
  - Reset mid-stream discards all phase information. The stream must be re-acquired from an anchor.
- err_count at all-ones: stays at all-ones. err continues to pulse.

## Test plan
- Clean stream after reset: 2, 1, 4, 1, 8 valid every cycle, LOCK_COUNT=4 -> SYNC after the 2. locked rises after the 8 (4th match). Continue to 128 -> frame pulses once, err_count stays 0.
- Leading 1s: 1, 1, 1, then 4 -> stays in HUNT through the 1s. Enters SYNC at the 4 with expected 8'h01 and step 4.
- Single glitch while locked: expected 16 at step 7, drive 8'h00 -> err pulse, err_count = 1. Next sample 1 (step 8) matches and locked stays 1.
- Loss of lock, MISS_LIMIT=3: three consecutive bad samples (8'h03, 8'h03, 8'h03) -> three err pulses, err_count += 3. locked falls after the third, step = 0, expected = 8'h00.
- Gaps and wrap: locked stream with in_valid low for 5 cycles between 128 and the following 1 -> no err. After the 128, step = 0 and expected = 8'h01. The 1 matches.
- Reset mid-operation: assert reset for 1 cycle while locked with err_count = 5 -> all outputs return to reset values. The stream re-locks from the next anchor.
